// File: rtl/triangle_rasterizer_pkg.sv
// Shared graphics types and widths for the triangle rasterizer: vertex layout,
// arithmetic widths, FSM states and small bounding-box helpers.
package triangle_rasterizer_pkg;

   localparam int COORD_W = 17;
   localparam int AREA_W  = 34;
   localparam int EDGE_W  = 35;
   localparam int AB_W    = 18;

   // [0] = x, [1] = y
   typedef logic [1:0][COORD_W-1:0] vertex_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP1,
      S_SETUP2,
      S_SETUP3,
      S_SCAN,
      S_DONE
   } state_t;

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   function automatic logic [COORD_W-1:0] clip_max(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/triangle_rasterizer_edge.sv
// Edge-function setup for one edge (va -> vb): A and B in the first setup
// cycle, the three products in the second, e(xmin, ymin) combinationally in the third.
module edge_function_setup
   import triangle_rasterizer_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  vertex_t                  va_i,
   input  vertex_t                  vb_i,
   input  logic [COORD_W-1:0]       xmin_i,
   input  logic [COORD_W-1:0]       ymin_i,
   output logic signed [AB_W-1:0]   a_o,
   output logic signed [AB_W-1:0]   b_o,
   output logic signed [EDGE_W-1:0] e_o
);

   logic signed [AB_W-1:0]   a_q, a_d, b_q, b_d;
   logic signed [EDGE_W-1:0] ax_q, ax_d, by_q, by_d, c_q, c_d;

   always_comb begin
      a_d  = $signed(AB_W'(vb_i[1]) - AB_W'(va_i[1]));
      b_d  = $signed(AB_W'(va_i[0]) - AB_W'(vb_i[0]));
      ax_d = EDGE_W'(a_q) * $signed(EDGE_W'(xmin_i));
      by_d = EDGE_W'(b_q) * $signed(EDGE_W'(ymin_i));
      c_d  = $signed(EDGE_W'(vb_i[0]) * EDGE_W'(va_i[1]) - EDGE_W'(va_i[0]) * EDGE_W'(vb_i[1]));
   end

   // NOTE: state is updated with <= so every stage samples the previous stage's
   // value from before the edge, independent of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_q  <= '0;
         b_q  <= '0;
         ax_q <= '0;
         by_q <= '0;
         c_q  <= '0;
      end else begin
         a_q  <= a_d;
         b_q  <= b_d;
         ax_q <= ax_d;
         by_q <= by_d;
         c_q  <= c_d;
      end
   end

   assign a_o = a_q;
   assign b_o = b_q;
   assign e_o = ax_q + by_q + c_q;

endmodule

// File: rtl/triangle_rasterizer.sv
// Walks the clipped bounding box of one triangle row-major with incremental
// edge functions and emits a fragment with barycentric weights per covered pixel.
module triangle_rasterizer
   import triangle_rasterizer_pkg::*;
#(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic [2:0][1:0][COORD_W-1:0]    vertices_in,
   input  logic                            negative_in,
   input  logic [AREA_W-1:0]               area_in,
   input  logic                            valid_in,
   output logic                            ready_out,
   output logic [COORD_W-1:0]              x_out,
   output logic [COORD_W-1:0]              y_out,
   output logic [2:0][AREA_W-1:0]          weights_out,
   output logic                            valid_out,
   input  logic                            ready_in,
   output logic                            done_out
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

   state_t                    state_q, state_d;
   vertex_t [2:0]             vert_q, vert_d;
   logic                      neg_q, neg_d;
   logic [AREA_W-1:0]         area_q, area_d;
   logic [COORD_W-1:0]        xmin_q, xmin_d, xmax_q, xmax_d;
   logic [COORD_W-1:0]        ymin_q, ymin_d, ymax_q, ymax_d;
   logic [COORD_W-1:0]        px_q, px_d, py_q, py_d;
   logic [2:0][EDGE_W-1:0]    e_q, e_d, erow_q, erow_d;
   logic                      last_q, last_d;
   logic                      valid_q, valid_d;
   logic [COORD_W-1:0]        x_q, x_d, y_q, y_d;
   logic [2:0][AREA_W-1:0]    w_q, w_d;

   logic signed [AB_W-1:0]    a_w [3];
   logic signed [AB_W-1:0]    b_w [3];
   logic [2:0][EDGE_W-1:0]    e_init;
   logic [2:0][EDGE_W-1:0]    a_ext, b_ext;
   logic                      covered;
   logic                      stall;

   // Edge i runs from vertex (i+1)%3 to vertex (i+2)%3.
   for (genvar i = 0; i < 3; i++) begin : g_edge
      edge_function_setup u_edge (
         .clk_i  (clk_in),
         .rst_i  (rst_in),
         .va_i   (vert_q[(i + 1) % 3]),
         .vb_i   (vert_q[(i + 2) % 3]),
         .xmin_i (xmin_q),
         .ymin_i (ymin_q),
         .a_o    (a_w[i]),
         .b_o    (b_w[i]),
         .e_o    (e_init[i])
      );
   end

   always_comb begin
      covered = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_ext[i] = EDGE_W'(a_w[i]);
         b_ext[i] = EDGE_W'(b_w[i]);
         if (neg_q) covered = covered & (e_q[i][EDGE_W-1] | (e_q[i] == '0));
         else       covered = covered & ~e_q[i][EDGE_W-1];
      end
   end

   assign stall = valid_q & ~ready_in;

   // NOTE: every signal assigned below gets its hold value first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      vert_d  = vert_q;
      neg_d   = neg_q;
      area_d  = area_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymin_d  = ymin_q;
      ymax_d  = ymax_q;
      px_d    = px_q;
      py_d    = py_q;
      e_d     = e_q;
      erow_d  = erow_q;
      last_d  = last_q;
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;

      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               vert_d  = vertices_in;
               neg_d   = negative_in;
               area_d  = area_in;
               state_d = S_SETUP1;
            end
         end
         S_SETUP1: begin
            xmin_d  = min3(vert_q[0][0], vert_q[1][0], vert_q[2][0]);
            ymin_d  = min3(vert_q[0][1], vert_q[1][1], vert_q[2][1]);
            xmax_d  = clip_max(max3(vert_q[0][0], vert_q[1][0], vert_q[2][0]), X_LAST);
            ymax_d  = clip_max(max3(vert_q[0][1], vert_q[1][1], vert_q[2][1]), Y_LAST);
            state_d = S_SETUP2;
         end
         S_SETUP2: state_d = S_SETUP3;
         S_SETUP3: begin
            px_d   = xmin_q;
            py_d   = ymin_q;
            e_d    = e_init;
            erow_d = e_init;
            last_d = 1'b0;
            if (area_q == '0 || xmin_q > X_LAST || ymin_q > Y_LAST) state_d = S_DONE;
            else                                                    state_d = S_SCAN;
         end
         S_SCAN: begin
            if (!stall) begin
               valid_d = 1'b0;
               if (last_q) begin
                  state_d = S_DONE;
               end else begin
                  if (covered) begin
                     valid_d = 1'b1;
                     x_d     = px_q;
                     y_d     = py_q;
                     for (int i = 0; i < 3; i++)
                        w_d[i] = neg_q ? -e_q[i][AREA_W-1:0] : e_q[i][AREA_W-1:0];
                  end
                  if (px_q == xmax_q) begin
                     if (py_q == ymax_q) begin
                        last_d = 1'b1;
                     end else begin
                        px_d = xmin_q;
                        py_d = py_q + COORD_W'(1);
                        for (int i = 0; i < 3; i++) begin
                           erow_d[i] = erow_q[i] + b_ext[i];
                           e_d[i]    = erow_q[i] + b_ext[i];
                        end
                     end
                  end else begin
                     px_d = px_q + COORD_W'(1);
                     for (int i = 0; i < 3; i++) e_d[i] = e_q[i] + a_ext[i];
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         vert_q  <= '0;
         neg_q   <= 1'b0;
         area_q  <= '0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymin_q  <= '0;
         ymax_q  <= '0;
         px_q    <= '0;
         py_q    <= '0;
         e_q     <= '0;
         erow_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         vert_q  <= vert_d;
         neg_q   <= neg_d;
         area_q  <= area_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         px_q    <= px_d;
         py_q    <= py_d;
         e_q     <= e_d;
         erow_q  <= erow_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
      end
   end

   assign ready_out   = (state_q == S_IDLE);
   assign done_out    = (state_q == S_DONE);
   assign valid_out   = valid_q;
   assign x_out       = x_q;
   assign y_out       = y_q;
   assign weights_out = w_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed bench for triangle_rasterizer: fragments are compared against a
// direct (non-incremental) edge-function model plus hand-computed constants.
module tb_triangle_rasterizer;

   localparam int WIDTH  = 320;
   localparam int HEIGHT = 240;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic [2:0][1:0][16:0] vertices_in;
   logic                 negative_in;
   logic [33:0]          area_in;
   logic                 valid_in;
   logic                 ready_out;
   logic [16:0]          x_out, y_out;
   logic [2:0][33:0]     weights_out;
   logic                 valid_out;
   logic                 ready_in;
   logic                 done_out;

   typedef struct {
      int     x;
      int     y;
      longint w0;
      longint w1;
      longint w2;
   } frag_t;

   frag_t  exp_q[$];
   int     tests = 0;
   int     fails = 0;
   int     first_cyc, done_cyc, got;
   int     max_x, max_y;
   logic [63:0] first_x, first_y, first_w0, first_w1, first_w2;

   triangle_rasterizer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .vertices_in (vertices_in),
      .negative_in (negative_in),
      .area_in     (area_in),
      .valid_in    (valid_in),
      .ready_out   (ready_out),
      .x_out       (x_out),
      .y_out       (y_out),
      .weights_out (weights_out),
      .valid_out   (valid_out),
      .ready_in    (ready_in),
      .done_out    (done_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic build_exp(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input bit neg, input longint area);
      int     xmn, xmx, ymn, ymx;
      longint e0, e1, e2;
      frag_t  f;
      exp_q.delete();
      xmn = imin(x0, imin(x1, x2));
      ymn = imin(y0, imin(y1, y2));
      xmx = imin(imax(x0, imax(x1, x2)), WIDTH - 1);
      ymx = imin(imax(y0, imax(y1, y2)), HEIGHT - 1);
      if (area == 0) return;
      for (int py = ymn; py <= ymx; py++) begin
         for (int px = xmn; px <= xmx; px++) begin
            e0 = longint'(y2 - y1) * px + longint'(x1 - x2) * py + longint'(x2) * y1 - longint'(x1) * y2;
            e1 = longint'(y0 - y2) * px + longint'(x2 - x0) * py + longint'(x0) * y2 - longint'(x2) * y0;
            e2 = longint'(y1 - y0) * px + longint'(x0 - x1) * py + longint'(x1) * y0 - longint'(x0) * y1;
            if (neg ? (e0 <= 0 && e1 <= 0 && e2 <= 0) : (e0 >= 0 && e1 >= 0 && e2 >= 0)) begin
               f.x  = px;
               f.y  = py;
               f.w0 = neg ? -e0 : e0;
               f.w1 = neg ? -e1 : e1;
               f.w2 = neg ? -e2 : e2;
               exp_q.push_back(f);
            end
         end
      end
   endtask

   // Returns at the falling edge of cycle T+1 (handshake at the end of cycle T).
   task automatic offer(input int x0, input int y0, input int x1, input int y1,
                        input int x2, input int y2, input bit neg, input longint area);
      @(negedge clk_in);
      vertices_in[0][0] = 17'(x0);
      vertices_in[0][1] = 17'(y0);
      vertices_in[1][0] = 17'(x1);
      vertices_in[1][1] = 17'(y1);
      vertices_in[2][0] = 17'(x2);
      vertices_in[2][1] = 17'(y2);
      negative_in = neg;
      area_in     = 34'(area);
      valid_in    = 1'b1;
      check("ready_before_handshake", ready_out, 1);
      @(posedge clk_in);
      @(negedge clk_in);
      valid_in = 1'b0;
      check("ready_low_in_setup", ready_out, 0);
   endtask

   // mode 0: ready_in held high; mode 1: 10-cycle stall after 3 fragments, then random.
   task automatic collect(input int mode, input longint area);
      int          k;
      int          stall_left;
      bit          stalled_once, held, done_seen;
      logic [16:0] hx, hy;
      logic [2:0][33:0] hw;
      k = 1; got = 0; stall_left = 0; stalled_once = 0; held = 0; done_seen = 0;
      first_cyc = -1; done_cyc = -1; max_x = -1; max_y = -1;
      while (k < 600) begin
         if (held) begin
            check("stall_valid_held", valid_out, 1);
            check("stall_x_held", x_out, hx);
            check("stall_y_held", y_out, hy);
            for (int i = 0; i < 3; i++) check("stall_w_held", weights_out[i], hw[i]);
         end
         if (done_out) begin
            check("no_valid_in_done", valid_out, 0);
            done_cyc  = k;
            done_seen = 1;
            break;
         end
         if (mode == 1 && got >= 3 && !stalled_once) begin
            stall_left   = 10;
            stalled_once = 1;
         end
         if (stall_left > 0) begin
            ready_in = 1'b0;
            stall_left--;
         end else if (mode == 1 && stalled_once) begin
            ready_in = 1'($urandom_range(0, 1));
         end else begin
            ready_in = 1'b1;
         end
         held = 0;
         if (valid_out) begin
            if (first_cyc < 0) first_cyc = k;
            if (ready_in) begin
               if (got == 0) begin
                  first_x  = x_out;
                  first_y  = y_out;
                  first_w0 = weights_out[0];
                  first_w1 = weights_out[1];
                  first_w2 = weights_out[2];
               end
               if (got < exp_q.size()) begin
                  check("frag_x", x_out, exp_q[got].x);
                  check("frag_y", y_out, exp_q[got].y);
                  check("frag_w0", weights_out[0], exp_q[got].w0);
                  check("frag_w1", weights_out[1], exp_q[got].w1);
                  check("frag_w2", weights_out[2], exp_q[got].w2);
                  check("frag_wsum", 64'(weights_out[0]) + 64'(weights_out[1]) + 64'(weights_out[2]),
                        area);
               end else begin
                  check("extra_fragment", got, exp_q.size());
               end
               max_x = imax(max_x, int'(x_out));
               max_y = imax(max_y, int'(y_out));
               got++;
            end else begin
               held = 1;
               hx   = x_out;
               hy   = y_out;
               hw   = weights_out;
            end
         end
         @(negedge clk_in);
         k++;
      end
      ready_in = 1'b1;
      check("done_seen", done_seen, 1);
   endtask

   task automatic after_done();
      @(negedge clk_in);
      check("ready_after_done", ready_out, 1);
      check("done_one_cycle", done_out, 0);
   endtask

   initial begin
      rst_in      = 1'b1;
      valid_in    = 1'b0;
      ready_in    = 1'b1;
      negative_in = 1'b0;
      area_in     = '0;
      vertices_in = '0;
      repeat (2) @(negedge clk_in);
      check("rst_valid", valid_out, 0);
      check("rst_done", done_out, 0);
      check("rst_ready", ready_out, 1);
      check("rst_x", x_out, 0);
      check("rst_y", y_out, 0);
      check("rst_w", weights_out, 0);
      rst_in = 1'b0;

      // Negative-area right triangle: 15 fragments, first (0,0) with (16,0,0).
      build_exp(0, 0, 4, 0, 0, 4, 1'b1, 16);
      offer(0, 0, 4, 0, 0, 4, 1'b1, 16);
      collect(0, 16);
      check("neg_count", got, 15);
      check("neg_first_x", first_x, 0);
      check("neg_first_y", first_y, 0);
      check("neg_first_w0", first_w0, 16);
      check("neg_first_w1", first_w1, 0);
      check("neg_first_w2", first_w2, 0);
      after_done();

      // Positive-area winding: same coverage, first fragment at T+5.
      build_exp(0, 0, 0, 4, 4, 0, 1'b0, 16);
      offer(0, 0, 0, 4, 4, 0, 1'b0, 16);
      collect(0, 16);
      check("pos_count", got, 15);
      check("pos_first_latency", first_cyc, 5);
      check("pos_first_w0", first_w0, 16);
      after_done();

      // Collinear: no fragments, done at T+4.
      build_exp(0, 0, 2, 2, 4, 4, 1'b0, 0);
      offer(0, 0, 2, 2, 4, 4, 1'b0, 0);
      collect(0, 0);
      check("degen_count", got, 0);
      check("degen_done_cycle", done_cyc, 4);
      after_done();

      // Entirely right of the screen: empty after clip.
      build_exp(400, 10, 410, 10, 400, 20, 1'b1, 50);
      offer(400, 10, 410, 10, 400, 20, 1'b1, 50);
      collect(0, 50);
      check("empty_count", got, 0);
      check("empty_done_cycle", done_cyc, 4);
      after_done();

      // Back-pressure: long stall then random ready.
      build_exp(0, 0, 4, 0, 0, 4, 1'b1, 16);
      offer(0, 0, 4, 0, 0, 4, 1'b1, 16);
      collect(1, 16);
      check("stall_count", got, 15);
      after_done();

      // Right-edge clip.
      build_exp(316, 0, 324, 0, 316, 8, 1'b1, 64);
      offer(316, 0, 324, 0, 316, 8, 1'b1, 64);
      collect(0, 64);
      check("clip_count", got, 30);
      check("clip_max_x", max_x, 319);
      check("clip_max_y", max_y, 8);
      check("clip_first_y", first_y, 0);
      check("clip_first_x", first_x, 316);
      after_done();

      // Reset in the middle of SCAN, then a clean triangle.
      offer(0, 0, 4, 0, 0, 4, 1'b1, 16);
      repeat (6) @(negedge clk_in);
      check("pre_reset_valid", valid_out, 1);
      rst_in = 1'b1;
      #1;
      check("midrst_valid", valid_out, 0);
      check("midrst_ready", ready_out, 1);
      check("midrst_done", done_out, 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      build_exp(0, 0, 0, 4, 4, 0, 1'b0, 16);
      offer(0, 0, 0, 4, 4, 0, 1'b0, 16);
      collect(0, 16);
      check("post_rst_count", got, 15);
      check("post_rst_latency", first_cyc, 5);
      after_done();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/triangle_rasterizer.md
# triangle_rasterizer

Consumes one triangle (three screen-space vertices plus its signed area from the area stage) and walks its clipped bounding box in row-major order. For every covered pixel it emits one fragment carrying the pixel coordinate and three unnormalised barycentric weights. It sits directly downstream of the triangle area computation and upstream of fragment shading and depth test.

## Interface

Parameters:
- `WIDTH`, 320, screen width in pixels; x is clipped to [0, WIDTH-1].
- `HEIGHT`, 240, screen height in pixels; y is clipped to [0, HEIGHT-1].

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `vertices_in`  in  [2:0][1:0][16:0]  vertex i: [i][0]=x, [i][1]=y, unsigned integer pixels, origin top-left.
- `negative_in`  in  1  signed area < 0.
- `area_in`  in  34  |signed area|.
- `valid_in`  in  1  triangle offered.
- `ready_out`  out  1  block can accept a triangle (high only in IDLE).
- `x_out`, `y_out`  out  17 each  fragment pixel coordinate.
- `weights_out`  out  [2:0][33:0]  |e0|, |e1|, |e2|; the sum equals area.
- `valid_out`  out  1  fragment valid.
- `ready_in`  in  1  downstream accepts the fragment.
- `done_out`  out  1  one-cycle pulse when the triangle is fully retired.

## Operation

Edge functions, with the same winding convention as the area stage:
- e0 = A0·px + B0·py + C0, where A0 = y2−y1, B0 = x1−x2, C0 = x2·y1 − x1·y2.
- e1 uses the same form on (v2, v0); e2 on (v0, v1).
- e0 + e1 + e2 equals the signed area at every pixel.

Width rules:
- A and B are 18-bit signed.
- C and e are 35-bit signed.
- Weight magnitude is the 34-bit two's-complement negation when negative_in = 1.

Bounding box:
- xmin/xmax/ymin/ymax are taken over the vertices, with max values clipped to WIDTH-1 / HEIGHT-1.
- Empty after clip (xmin > WIDTH-1 or ymin > HEIGHT-1): no fragments.

Coverage rule:
- negative_in = 0: pixel covered iff all e ≥ 0.
- negative_in = 1: pixel covered iff all e ≤ 0.
- area_in = 0: degenerate triangle, no fragments.

Traversal:
- Incremental, no per-pixel multiplies.
- x++ adds A_i.
- Row wrap adds B_i and restores the row-start value.

FSM:
- IDLE: ready_out = 1. A handshake (valid_in & ready_out) latches vertices_in, negative_in and area_in, then goes to SETUP.
- SETUP: exactly 3 cycles.
  - Cycle 1: bbox, A, B.
  - Cycle 2: products.
  - Cycle 3: e at (xmin, ymin).
  - Then SCAN, or DONE directly if degenerate or empty.
- SCAN: evaluates one pixel per non-stalled cycle.
  - Stall condition: valid_out & !ready_in. While stalled, the scan position and all output registers are held.
  - After (xmax, ymax) is evaluated and no fragment is pending, go to DONE.
- DONE: one cycle, done_out = 1, then IDLE.

## Timing

- Reset state: IDLE; valid_out = 0, done_out = 0, x_out = y_out = weights_out = 0; ready_out = 1.
- Reset mid-triangle discards the triangle and any pending fragment immediately.
- Latency: handshake at cycle T → first pixel evaluated at T+4. A covered pixel evaluated at cycle t appears on outputs at t+1.
- Throughput: 1 pixel/cycle with ready_in held high. Uncovered pixels consume one cycle each and produce nothing.
- Output handshake: valid_out stays high with stable data until ready_in. A fragment may be replaced in the same cycle it is accepted.
- Zero-fragment triangles: done_out is asserted 4 cycles after the handshake. ready_out returns high the cycle after done_out.
- valid_in during non-IDLE states is ignored; the upstream holds it.

## Structure

- Shared graphics package holds:
  - the `vertex_t` ([1:0][16:0]) typedef;
  - the coordinate width 17, area width 34 and edge width 35 as constants;
  - the FSM state enum.
- One natural sub-module, `edge_function_setup`: computes A, B, C and the initial e for one edge. It is instantiated three times and pipelined to match SETUP.

## Test plan

- (0,0),(4,0),(0,4), negative_in = 1, area 16 → 15 fragments in row-major order; first is (0,0) with weights (16,0,0); every weight sum = 16; done_out follows.
- (0,0),(0,4),(4,0), negative_in = 0, area 16 → same 15 coordinates; first fragment at T+5.
- Collinear (0,0),(2,2),(4,4), area 0 → zero fragments; done_out at T+4.
- First case with ready_in low 10 cycles mid-stream, then random toggling → outputs stable while stalled; 15 fragments; no duplicates or losses.
- (316,0),(324,0),(316,8), negative_in = 1, area 64 → 30 fragments; all x ≤ 319; y spans 0..8.
- rst_in pulsed mid-SCAN → valid_out drops immediately, ready_out = 1; the next triangle rasterizes correctly.
